// File: rtl/clock_ctrl.sv
// Programmable processor clock controller.
// Divides clkin into a square clkout with an aligned one-cycle tick, and
// supports HALT, free RUN and single-STEP modes. Divisor updates are
// deferred to half-period boundaries so that no phase is ever truncated.
module clock_ctrl #(
    parameter int unsigned WIDTH       = 25,
    parameter int unsigned DEFAULT_DIV = 25_000_000
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clkout,
    output logic             tick,
    output logic             busy,
    output logic             load_pending
);

    localparam logic [1:0] ModeRun  = 2'b01;
    localparam logic [1:0] ModeStep = 2'b10;

    // STEP is split into its high and low phases so the first STEP cycle
    // is identifiable by clkout still being 0 in StStepHi.
    typedef enum logic [2:0] {
        StHalt,
        StRun,
        StStepHi,
        StStepLo,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_reg_q, div_reg_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             step_prev_q;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    logic             step_rise;
    logic             term;
    logic             apply;
    logic [WIDTH-1:0] count_inc;

    assign step_rise = step_req & ~step_prev_q;

    // Next-state, counter, clkout/tick and divisor update logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        clkout_d   = clkout_q;
        tick_d     = 1'b0;
        div_reg_d  = div_reg_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        apply      = 1'b0;
        // count > div_reg cannot normally happen; treat it as terminal anyway.
        term       = (count_q >= div_reg_q);
        count_inc  = count_q + WIDTH'(1);

        unique case (state_q)
            StHalt: begin
                count_d  = '0;
                clkout_d = 1'b0;
                if (mode == ModeRun) begin
                    state_d = StRun;
                end else if (mode == ModeStep && step_rise) begin
                    state_d = StStepHi;
                end
            end
            StRun: begin
                if (mode != ModeRun && !clkout_q) begin
                    state_d = StHalt;
                    count_d = '0;
                end else if (term) begin
                    count_d  = '0;
                    clkout_d = ~clkout_q;
                    apply    = 1'b1;
                    if (!clkout_q) begin
                        tick_d = 1'b1;
                    end else if (mode != ModeRun) begin
                        // Leaving RUN exactly on the falling toggle: no drain needed.
                        state_d = StHalt;
                    end
                end else begin
                    count_d = count_inc;
                    if (mode != ModeRun) begin
                        state_d = StDrain;
                    end
                end
            end
            StStepHi: begin
                if (!clkout_q) begin
                    clkout_d = 1'b1;
                    tick_d   = 1'b1;
                    count_d  = '0;
                end else if (term) begin
                    clkout_d = 1'b0;
                    count_d  = '0;
                    apply    = 1'b1;
                    state_d  = StStepLo;
                end else begin
                    count_d = count_inc;
                end
            end
            StStepLo: begin
                if (term) begin
                    count_d = '0;
                    apply   = 1'b1;
                    state_d = StHalt;
                end else begin
                    count_d = count_inc;
                end
            end
            StDrain: begin
                if (term) begin
                    clkout_d = 1'b0;
                    count_d  = '0;
                    apply    = 1'b1;
                    state_d  = StHalt;
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                state_d  = StHalt;
                count_d  = '0;
                clkout_d = 1'b0;
            end
        endcase

        // While halted a pending divisor is applied on the following cycle.
        if (state_q == StHalt && pend_q) begin
            div_reg_d = div_pend_q;
            pend_d    = 1'b0;
        end

        // At a half-period boundary a same-cycle load bypasses div_pend.
        if (apply) begin
            if (div_load) begin
                div_reg_d = div_in;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                div_reg_d = div_pend_q;
                pend_d    = 1'b0;
            end
        end else if (div_load) begin
            div_pend_d = div_in;
            pend_d     = 1'b1;
        end

        busy_d = (state_d != StHalt);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= StHalt;
            count_q     <= '0;
            div_reg_q   <= WIDTH'(DEFAULT_DIV);
            div_pend_q  <= WIDTH'(DEFAULT_DIV);
            pend_q      <= 1'b0;
            step_prev_q <= 1'b0;
            clkout_q    <= 1'b0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_reg_q   <= div_reg_d;
            div_pend_q  <= div_pend_d;
            pend_q      <= pend_d;
            step_prev_q <= step_req;
            clkout_q    <= clkout_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
        end
    end

    assign clkout       = clkout_q;
    assign tick         = tick_q;
    assign busy         = busy_q;
    assign load_pending = pend_q;

endmodule
